// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
// Iterative AES-128 key expansion with an 11-entry round-key bank.
// A cipher key is accepted over key_valid/key_ready. The engine then produces
// one round key per clock for 10 clocks using one shared SubWord unit
// (four S-boxes) and an Rcon table. Round keys are read back through a
// registered read port.
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   key_in       128-bit cipher key, w0 = key_in[127:96]
//   key_valid    key_in is valid
//   key_ready    engine accepts a key (IDLE or DONE)
//   flush        synchronous abort, wins over key_valid
//   busy         expansion in progress
//   done         one-cycle pulse when round key 10 is written
//   keys_valid   bank holds a complete schedule
//   rk_rd        read strobe
//   rk_addr      round-key index 0..10 (11..15 read as zero)
//   rk_data      registered read data
//   rk_ack       pulses the cycle after rk_rd
module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS   = 10,
  parameter bit FLUSH_CLEARS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic         rk_rd,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         rk_ack
);

  generate
    if (NUM_ROUNDS != 10) begin : g_bad_rounds
      $error("aes_key_sched_ctrl supports only NUM_ROUNDS = 10");
    end
  endgenerate

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  // AES S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    // byte b lives at bit offset 8*(255-b) = {~b, 3'b000}
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t       state;
  logic [3:0]   round;
  logic [127:0] work;   // previous round key, so the loop never reads the bank
  logic [127:0] bank [0:10];

  logic [31:0]  p0, p1, p2, p3, rot, t, q0, q1, q2, q3;
  logic [127:0] next_key;

  always_comb begin
    {p0, p1, p2, p3} = work;
    rot      = {p3[23:0], p3[31:24]};
    t        = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
                sub_byte(rot[15:8]),  sub_byte(rot[7:0])} ^ {rcon(round), 24'h0};
    q0       = p0 ^ t;
    q1       = p1 ^ q0;
    q2       = p2 ^ q1;
    q3       = p3 ^ q2;
    next_key = {q0, q1, q2, q3};
  end

  assign key_ready = (state != EXPAND);
  assign busy      = (state == EXPAND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      round      <= 4'd0;
      work       <= '0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i <= 10; i++) bank[i] <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state      <= IDLE;
        round      <= 4'd0;
        keys_valid <= 1'b0;
        if (FLUSH_CLEARS) begin
          for (int i = 0; i <= 10; i++) bank[i] <= '0;
        end
      end else begin
        case (state)
          IDLE, DONE: begin
            if (key_valid) begin
              bank[0]    <= key_in;
              work       <= key_in;
              round      <= 4'd1;
              keys_valid <= 1'b0;
              state      <= EXPAND;
            end
          end
          EXPAND: begin
            bank[round] <= next_key;
            work        <= next_key;
            if (round == LAST_ROUND) begin
              round      <= 4'd0;
              state      <= DONE;
              done       <= 1'b1;
              keys_valid <= 1'b1;
            end else begin
              round <= round + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Registered read port; non-blocking update of the bank gives
  // read-before-write on a same-edge collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_data <= '0;
      rk_ack  <= 1'b0;
    end else begin
      rk_ack <= rk_rd;
      if (rk_rd) begin
        rk_data <= (rk_addr <= 4'd10) ? bank[rk_addr] : 128'h0;
      end
    end
  end

endmodule
